// File: rtl/typer_draw_pkg.sv
// rtl/typer_draw_pkg.sv - resolution, text-grid, colour constants and engine state encoding
package typer_draw_pkg;

    localparam int H_RES         = 640;
    localparam int V_RES         = 480;
    localparam int CHARS_PER_ROW = 32;

    localparam logic [18:0] PIXELS          = 19'(H_RES * V_RES);
    localparam logic [18:0] LINE_STRIDE     = 19'(H_RES);
    localparam logic [18:0] CELL_ROW_STRIDE = 19'(8 * H_RES);

    localparam logic [2:0] FG_COLOR   = 3'b111;
    localparam logic [2:0] BG_COLOR   = 3'b000;
    localparam logic [2:0] DRAW_COLOR = 3'b010;

    typedef enum logic [1:0] {
        IDLE,
        T_FETCH,
        T_WRITE,
        D_WRITE
    } state_t;

endpackage

// File: rtl/char_index_to_pixel.sv
// rtl/char_index_to_pixel.sv - text-grid cell index to top-left pixel address of its 8x8 cell
module char_index_to_pixel
    import typer_draw_pkg::*;
(
    input  logic [7:0]  i_char_index,
    output logic [18:0] o_base
);

    logic [18:0] w_row_offset;
    logic [18:0] w_col_offset;

    // Low five bits pick the column (CHARS_PER_ROW wide), upper three the cell row.
    assign w_row_offset = {16'd0, i_char_index[7:5]} * CELL_ROW_STRIDE;
    assign w_col_offset = {11'd0, i_char_index[4:0], 3'b000};
    assign o_base       = w_row_offset + w_col_offset;

endmodule

// File: rtl/typer_draw_engine.sv
// rtl/typer_draw_engine.sv - single-port pixel writer: 8x8 glyph renderer or single-pixel plotter
module typer_draw_engine
    import typer_draw_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_typer_start,
    input  logic [7:0]  i_char_index,
    input  logic [7:0]  i_character,
    output logic [10:0] o_font_addr,
    input  logic [7:0]  i_font_row,
    output logic        o_typer_ready,
    input  logic        i_draw_start,
    input  logic [18:0] i_draw_pixeladdr,
    output logic        o_draw_ready,
    output logic [18:0] o_mem_waddr,
    output logic [2:0]  o_mem_wdata,
    output logic        o_mem_wenable
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_row;
    logic [2:0]  r_col;
    logic [7:0]  r_char;
    logic [7:0]  r_glyph;
    logic [18:0] r_base;

    logic [18:0] r_waddr;
    logic [18:0] w_waddr_nxt;
    logic [2:0]  r_wdata;
    logic [2:0]  w_wdata_nxt;
    logic        r_wen;
    logic        w_wen_nxt;
    logic [10:0] r_font_addr;
    logic [10:0] w_font_addr_nxt;
    logic        r_ready;
    logic        w_ready_nxt;

    logic [18:0] w_cell_base;
    logic [18:0] w_line_addr;
    logic [2:0]  w_next_col;
    logic        w_accept_t;
    logic        w_accept_d;

    char_index_to_pixel u_cell_base (
        .i_char_index (i_char_index),
        .o_base       (w_cell_base)
    );

    // Typer has priority when both requests land in the same idle cycle.
    assign w_accept_t  = (r_state == IDLE) && i_typer_start;
    assign w_accept_d  = (r_state == IDLE) && !i_typer_start && i_draw_start;
    assign w_line_addr = r_base + ({16'd0, r_row} * LINE_STRIDE);
    assign w_next_col  = r_col + 3'd1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_row       <= 3'd0;
            r_col       <= 3'd0;
            r_char      <= 8'd0;
            r_glyph     <= 8'd0;
            r_base      <= 19'd0;
            r_waddr     <= 19'd0;
            r_wdata     <= 3'd0;
            r_wen       <= 1'b0;
            r_font_addr <= 11'd0;
            r_ready     <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_waddr     <= w_waddr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_wen       <= w_wen_nxt;
            r_font_addr <= w_font_addr_nxt;
            r_ready     <= w_ready_nxt;
            if (w_accept_t) begin
                r_char <= i_character;
                r_base <= w_cell_base;
                r_row  <= 3'd0;
            end
            // ROM row is presented throughout FETCH and latched as WRITE begins.
            if (r_state == T_FETCH) begin
                r_glyph <= i_font_row;
                r_col   <= 3'd0;
            end
            if (r_state == T_WRITE) begin
                r_col <= w_next_col;
                if (r_col == 3'd7) r_row <= r_row + 3'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept_t)      w_state_nxt = T_FETCH;
                else if (w_accept_d) w_state_nxt = D_WRITE;
            end
            T_FETCH: w_state_nxt = T_WRITE;
            T_WRITE: begin
                if (r_col == 3'd7) w_state_nxt = (r_row == 3'd7) ? IDLE : T_FETCH;
            end
            D_WRITE: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Computes the value each output register takes at the next edge.
    always_comb begin
        w_waddr_nxt     = r_waddr;
        w_wdata_nxt     = r_wdata;
        w_wen_nxt       = 1'b0;
        w_font_addr_nxt = r_font_addr;
        w_ready_nxt     = r_ready;
        case (r_state)
            IDLE: begin
                if (w_accept_t) begin
                    w_font_addr_nxt = {i_character, 3'd0};
                    w_ready_nxt     = 1'b0;
                end else if (w_accept_d) begin
                    w_ready_nxt = 1'b0;
                    if (i_draw_pixeladdr < PIXELS) begin
                        w_waddr_nxt = i_draw_pixeladdr;
                        w_wdata_nxt = DRAW_COLOR;
                        w_wen_nxt   = 1'b1;
                    end
                end
            end
            T_FETCH: begin
                w_waddr_nxt = w_line_addr;
                w_wdata_nxt = i_font_row[7] ? FG_COLOR : BG_COLOR;
                w_wen_nxt   = 1'b1;
            end
            T_WRITE: begin
                if (r_col == 3'd7) begin
                    if (r_row == 3'd7) w_ready_nxt = 1'b1;
                    else               w_font_addr_nxt = {r_char, r_row + 3'd1};
                end else begin
                    w_waddr_nxt = w_line_addr + {16'd0, w_next_col};
                    w_wdata_nxt = r_glyph[3'd7 - w_next_col] ? FG_COLOR : BG_COLOR;
                    w_wen_nxt   = 1'b1;
                end
            end
            D_WRITE: w_ready_nxt = 1'b1;
            default: w_ready_nxt = 1'b1;
        endcase
    end

    assign o_font_addr   = r_font_addr;
    assign o_typer_ready = r_ready;
    assign o_draw_ready  = r_ready;
    assign o_mem_waddr   = r_waddr;
    assign o_mem_wdata   = r_wdata;
    assign o_mem_wenable = r_wen;

endmodule

// File: tb/tb_typer_draw_engine.sv
// tb/tb_typer_draw_engine.sv - randomized self-checking bench for typer_draw_engine
module tb_typer_draw_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        typer_start;
    logic [7:0]  char_index;
    logic [7:0]  character;
    logic [10:0] font_addr;
    logic [7:0]  font_row;
    logic        typer_ready;
    logic        draw_start;
    logic [18:0] draw_pixeladdr;
    logic        draw_ready;
    logic [18:0] mem_waddr;
    logic [2:0]  mem_wdata;
    logic        mem_wenable;

    typedef struct packed {
        logic [18:0] a;
        logic [2:0]  d;
    } wr_t;

    logic [7:0] font_mem [0:2047];
    wr_t        obs_q [$];
    wr_t        exp_q [$];
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;
    assign font_row = font_mem[font_addr];

    typer_draw_engine dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_typer_start    (typer_start),
        .i_char_index     (char_index),
        .i_character      (character),
        .o_font_addr      (font_addr),
        .i_font_row       (font_row),
        .o_typer_ready    (typer_ready),
        .i_draw_start     (draw_start),
        .i_draw_pixeladdr (draw_pixeladdr),
        .o_draw_ready     (draw_ready),
        .o_mem_waddr      (mem_waddr),
        .o_mem_wdata      (mem_wdata),
        .o_mem_wenable    (mem_wenable)
    );

    always @(negedge clk) begin
        if (rst_n && mem_wenable) obs_q.push_back(wr_t'({mem_waddr, mem_wdata}));
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic model_typer(input logic [7:0] idx, input logic [7:0] ch);
        int base;
        exp_q.delete();
        base = (idx / 32) * 8 * 640 + (idx % 32) * 8;
        for (int r = 0; r < 8; r++) begin
            logic [7:0] bits;
            bits = font_mem[ch * 8 + r];
            for (int c = 0; c < 8; c++)
                exp_q.push_back(wr_t'({19'(base + r * 640 + c), (bits[7 - c] ? 3'b111 : 3'b000)}));
        end
    endtask

    task automatic model_draw(input int addr);
        exp_q.delete();
        if (addr < 640 * 480) exp_q.push_back(wr_t'({19'(addr), 3'b010}));
    endtask

    task automatic compare_writes(input string tag);
        check({tag, " write count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check($sformatf("%s addr[%0d]", tag, i), obs_q[i].a, exp_q[i].a);
            check($sformatf("%s data[%0d]", tag, i), obs_q[i].d, exp_q[i].d);
        end
    endtask

    task automatic fill_font(input int mode);
        for (int i = 0; i < 2048; i++) begin
            case (mode)
                0:       font_mem[i] = 8'hFF;
                1:       font_mem[i] = (i % 2 == 0) ? 8'hAA : 8'h55;
                default: font_mem[i] = 8'($urandom);
            endcase
        end
    endtask

    task automatic run_typer(input string tag, input logic [7:0] idx, input logic [7:0] ch,
                             input bit with_draw, input bit busy_draw);
        int cyc;
        model_typer(idx, ch);
        obs_q.delete();
        typer_start    = 1'b1;
        char_index     = idx;
        character      = ch;
        draw_start     = with_draw;
        draw_pixeladdr = 19'd1000;
        tick();
        typer_start = 1'b0;
        draw_start  = 1'b0;
        char_index  = 8'($urandom);
        character   = 8'($urandom);
        cyc = 1;
        while (!typer_ready && cyc < 200) begin
            if ((cyc - 1) % 9 == 0)
                check($sformatf("%s font_addr row%0d", tag, (cyc - 1) / 9), font_addr,
                      {21'd0, ch, 3'((cyc - 1) / 9)});
            draw_start = busy_draw && (cyc == 20);
            tick();
            cyc++;
        end
        draw_start = 1'b0;
        check({tag, " ready cycle"}, cyc, 73);
        compare_writes(tag);
    endtask

    task automatic run_draw(input string tag, input int addr);
        model_draw(addr);
        obs_q.delete();
        draw_start     = 1'b1;
        draw_pixeladdr = 19'(addr);
        tick();
        draw_start = 1'b0;
        check({tag, " busy draw_ready"}, draw_ready, 0);
        check({tag, " busy typer_ready"}, typer_ready, 0);
        tick();
        check({tag, " draw_ready back"}, draw_ready, 1);
        tick();
        compare_writes(tag);
    endtask

    initial begin
        rst_n          = 1'b0;
        typer_start    = 1'b0;
        draw_start     = 1'b0;
        char_index     = 8'd0;
        character      = 8'd0;
        draw_pixeladdr = 19'd0;
        fill_font(2);
        tick();
        tick();
        check("reset typer_ready", typer_ready, 1);
        check("reset draw_ready", draw_ready, 1);
        check("reset wenable", mem_wenable, 0);
        check("reset waddr", mem_waddr, 0);
        check("reset wdata", mem_wdata, 0);
        check("reset font_addr", font_addr, 0);
        rst_n = 1'b1;
        tick();

        fill_font(0);
        run_typer("typer_ff", 8'd0, 8'h41, 1'b0, 1'b0);
        fill_font(1);
        run_typer("typer_aa55", 8'd33, 8'h42, 1'b0, 1'b0);
        run_draw("draw_1000", 1000);
        run_draw("draw_oob", 307200);
        run_draw("draw_last", 307199);
        fill_font(2);
        run_typer("both_start", 8'd7, 8'h5A, 1'b1, 1'b0);
        run_typer("busy_draw", 8'd255, 8'hC3, 1'b0, 1'b1);

        // Reset during row 3 of a typer job.
        obs_q.delete();
        typer_start = 1'b1;
        char_index  = 8'd5;
        character   = 8'h33;
        tick();
        typer_start = 1'b0;
        for (int i = 1; i < 31; i++) tick();
        check("midjob wenable", mem_wenable, 1);
        rst_n = 1'b0;
        #1;
        check("midreset wenable", mem_wenable, 0);
        check("midreset waddr", mem_waddr, 0);
        check("midreset wdata", mem_wdata, 0);
        check("midreset font_addr", font_addr, 0);
        check("midreset typer_ready", typer_ready, 1);
        obs_q.delete();
        tick();
        tick();
        check("midreset writes", obs_q.size(), 0);
        rst_n = 1'b1;
        tick();
        run_typer("after_reset", 8'd100, 8'h7E, 1'b0, 1'b0);

        for (int n = 0; n < 10; n++) begin
            if ($urandom_range(0, 1) == 0) begin
                fill_font(2);
                run_typer($sformatf("rand_typer%0d", n), 8'($urandom), 8'($urandom), 1'b0, 1'b0);
            end else begin
                run_draw($sformatf("rand_draw%0d", n), int'($urandom_range(300000, 310000)));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
